// File: rtl/din_debounce_sync.sv
// din_debounce_sync
//   Conditions a raw asynchronous input (button/switch) for the downstream
//   single-bit D flip-flop: synchronizes it into the clk domain, accepts a
//   change only after STABLE consecutive identical synchronized samples, and
//   derives edge pulses, a toggle and a wrapping press counter.
//
// Parameters
//   SYNC_STAGES : synchronizer depth (>= 2)
//   STABLE      : consecutive identical samples required to accept a change (>= 2)
//   CNT_W       : stable-counter width, 2**CNT_W must exceed STABLE
//   PRESS_W     : press-counter width
//
// Ports
//   clk        in   system clock, all state updates on posedge
//   rst        in   asynchronous active-high reset, clears all state
//   din        in   raw asynchronous input
//   level      out  debounced level, feeds D of the downstream flip-flop
//   rise       out  one-cycle pulse on an accepted 0->1 change
//   fall       out  one-cycle pulse on an accepted 1->0 change
//   tog        out  inverts on every rise pulse
//   press_cnt  out  accepted-rise count, wraps modulo 2**PRESS_W
module din_debounce_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STABLE      = 4,
    parameter int unsigned CNT_W       = 3,
    parameter int unsigned PRESS_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    output logic               level,
    output logic               rise,
    output logic               fall,
    output logic               tog,
    output logic [PRESS_W-1:0] press_cnt
);

    typedef enum logic [1:0] {
        S_LOW     = 2'd0,
        S_QUAL_HI = 2'd1,
        S_HIGH    = 2'd2,
        S_QUAL_LO = 2'd3
    } state_t;

    // Counter value at which the STABLE-th identical sample is being seen.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   din_s;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   tog_q;
    logic [PRESS_W-1:0]     press_cnt_q;

    logic [CNT_W-1:0]       cnt_d;
    logic                   tog_d;
    logic [PRESS_W-1:0]     press_cnt_d;

    // ------------------------------------------------------------------
    // Synchronizer: plain shift chain, nothing between stages.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign din_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Arithmetic helpers used by the FSM on the accepting edge.
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d       = cnt_q + 1'b1;
        tog_d       = ~tog_q;
        press_cnt_d = press_cnt_q + 1'b1;
    end

    // ------------------------------------------------------------------
    // Debounce FSM with registered outputs. rise/fall default low so
    // each is asserted for exactly the accepting edge only.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_LOW;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            tog_q       <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                S_LOW: begin
                    level_q <= 1'b0;
                    if (din_s) begin
                        state_q <= S_QUAL_HI;
                        cnt_q   <= CNT_W'(1);
                    end else begin
                        cnt_q   <= '0;
                    end
                end

                S_QUAL_HI: begin
                    if (!din_s) begin
                        // Excursion too short: drop back without a pulse.
                        state_q <= S_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= S_HIGH;
                        cnt_q       <= '0;
                        level_q     <= 1'b1;
                        rise_q      <= 1'b1;
                        tog_q       <= tog_d;
                        press_cnt_q <= press_cnt_d;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                S_HIGH: begin
                    level_q <= 1'b1;
                    if (!din_s) begin
                        state_q <= S_QUAL_LO;
                        cnt_q   <= CNT_W'(1);
                    end else begin
                        cnt_q   <= '0;
                    end
                end

                S_QUAL_LO: begin
                    if (din_s) begin
                        state_q <= S_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_LOW;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                default: begin
                    state_q <= S_LOW;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign level     = level_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign tog       = tog_q;
    assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_din_debounce_sync.sv
module tb_din_debounce_sync;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned STABLE      = 4;
    localparam int unsigned CNT_W       = 3;
    localparam int unsigned PRESS_W     = 4;

    logic               clk;
    logic               rst;
    logic               din;
    logic               level;
    logic               rise;
    logic               fall;
    logic               tog;
    logic [PRESS_W-1:0] press_cnt;

    din_debounce_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .STABLE      (STABLE),
        .CNT_W       (CNT_W),
        .PRESS_W     (PRESS_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .level     (level),
        .rise      (rise),
        .fall      (fall),
        .tog       (tog),
        .press_cnt (press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: din_s at an edge is the din sampled SYNC_STAGES edges
    // earlier; the level flips once STABLE consecutive such samples differ.
    bit m_hist[$];
    int m_run;
    bit m_level, m_rise, m_fall, m_tog;
    int m_cnt;

    int rise_seen, fall_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < int'(SYNC_STAGES); i++) m_hist.push_back(1'b0);
        m_run   = 0;
        m_level = 1'b0;
        m_rise  = 1'b0;
        m_fall  = 1'b0;
        m_tog   = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic model_step();
        bit s;
        if (rst) begin
            model_reset();
            return;
        end
        s = m_hist.pop_front();
        m_hist.push_back(din);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (s != m_level) begin
            m_run++;
            if (m_run == int'(STABLE)) begin
                m_level = s;
                m_run   = 0;
                if (s) begin
                    m_rise = 1'b1;
                    m_tog  = ~m_tog;
                    m_cnt  = (m_cnt + 1) % (1 << PRESS_W);
                end else begin
                    m_fall = 1'b1;
                end
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("level", level, m_level);
        chk("rise", rise, m_rise);
        chk("fall", fall, m_fall);
        chk("tog", tog, m_tog);
        chk("press_cnt", press_cnt, m_cnt);
        chk("rise_fall_excl", rise & fall, 1'b0);
        if (rise) rise_seen++;
        if (fall) fall_seen++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int r0, f0, len;
        bit lvl0;

        rst = 1'b1;
        din = 1'b0;
        rise_seen = 0;
        fall_seen = 0;
        model_reset();
        #1;
        chk("reset_level", level, 1'b0);
        chk("reset_tog", tog, 1'b0);
        chk("reset_press_cnt", press_cnt, 0);
        ticks(2);
        @(negedge clk);
        rst = 1'b0;

        // First press: level rises on the 6th edge after din is first sampled.
        din = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e < 6) chk("lat_rise_early", rise, 1'b0);
        end
        chk("lat_rise_e6", rise, 1'b1);
        chk("lat_level_e6", level, 1'b1);
        chk("lat_tog_e6", tog, 1'b1);
        chk("lat_cnt_e6", press_cnt, 1);
        ticks(10);

        // Short low glitch from stable high.
        r0 = rise_seen; f0 = fall_seen;
        din = 1'b0;
        ticks(3);
        din = 1'b1;
        ticks(12);
        chk("glitch_level", level, 1'b1);
        chk("glitch_rise", rise_seen - r0, 0);
        chk("glitch_fall", fall_seen - f0, 0);
        chk("glitch_cnt", press_cnt, 1);

        // Held low: fall on the 6th edge, tog unchanged.
        din = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e < 6) chk("lat_fall_early", fall, 1'b0);
        end
        chk("lat_fall_e6", fall, 1'b1);
        chk("lat_fall_level", level, 1'b0);
        chk("lat_fall_tog", tog, 1'b1);
        ticks(4);

        // 17 clean press/release cycles from reset: counter wraps 15->0->1.
        @(negedge clk);
        rst = 1'b1;
        tick();
        @(negedge clk);
        rst = 1'b0;
        r0 = rise_seen; f0 = fall_seen;
        for (int p = 0; p < 17; p++) begin
            din = 1'b1;
            ticks(10);
            din = 1'b0;
            ticks(10);
        end
        ticks(6);
        chk("wrap_cnt", press_cnt, 1);
        chk("wrap_tog", tog, 1'b1);
        chk("wrap_rises", rise_seen - r0, 17);
        chk("wrap_falls", fall_seen - f0, 17);

        // Reset during high qualification (counter at 2), din kept high.
        din = 1'b1;
        ticks(4);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("midrst_level", level, 1'b0);
        chk("midrst_tog", tog, 1'b0);
        chk("midrst_cnt", press_cnt, 0);
        tick();
        #2;
        rst = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e < 6) chk("midrst_rise_early", rise, 1'b0);
        end
        chk("midrst_rise_e6", rise, 1'b1);
        chk("midrst_cnt_e6", press_cnt, 1);
        ticks(8);

        // Toggle every cycle: never qualifies.
        lvl0 = level;
        r0 = rise_seen; f0 = fall_seen;
        for (int i = 0; i < 50; i++) begin
            din = ~din;
            tick();
        end
        chk("toggle_level", level, lvl0);
        chk("toggle_rise", rise_seen - r0, 0);
        chk("toggle_fall", fall_seen - f0, 0);

        // Random runs of length 1..8, checked every edge against the model.
        for (int k = 0; k < 150; k++) begin
            din = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 8));
            ticks(len);
        end
        ticks(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Backstop so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/din_debounce_sync.md
Name: din_debounce_sync

Overview:
- Upstream conditioning stage for the single-bit D flip-flop.
- Takes a raw asynchronous input (button or switch), synchronizes it into the clk domain and qualifies it with a stable-count debounce.
- Produces a clean level that drives the flip-flop's D input, plus one-cycle rise/fall pulses, a toggle output and a wrapping press counter.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops; legal range ≥2.
- STABLE, 4, consecutive identical synchronized samples required to accept a change; legal range ≥2.
- CNT_W, 3, width of the stable counter; must satisfy 2^CNT_W > STABLE.
- PRESS_W, 4, width of the press counter.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- din  input  1  raw asynchronous input.
- level  output  1  debounced, synchronized level; feeds D of the downstream flip-flop.
- rise  output  1  one-cycle pulse on an accepted 0→1 change.
- fall  output  1  one-cycle pulse on an accepted 1→0 change.
- tog  output  1  inverts on every rise pulse.
- press_cnt  output  PRESS_W  count of accepted rises; wraps modulo 2^PRESS_W.

Behaviour:
- Clocking and reset:
  - One clock: clk.
  - Reset is asynchronous and active-high (rst); rst high forces all state immediately, independent of clk.
- Reset values:
  - All sync flops 0; state S_LOW; stable counter 0.
  - level=0, rise=0, fall=0, tog=0, press_cnt=0.
- Synchronizer:
  - SYNC_STAGES-flop shift chain; din_s is the last stage.
  - No logic is placed between stages.
- FSM states: S_LOW, S_QUAL_HI, S_HIGH, S_QUAL_LO.
  - S_LOW (level=0):
    - din_s=1 → S_QUAL_HI, cnt<=1.
    - Otherwise stay, cnt<=0.
  - S_QUAL_HI (level=0):
    - din_s=0 → S_LOW, cnt<=0 (glitch rejected, no pulse).
    - din_s=1 and cnt==STABLE-1 → S_HIGH; on the same edge: level<=1, rise<=1, tog<=~tog, press_cnt<=press_cnt+1.
    - Otherwise cnt<=cnt+1.
  - S_HIGH (level=1):
    - din_s=0 → S_QUAL_LO, cnt<=1.
    - Otherwise stay.
  - S_QUAL_LO: mirror of S_QUAL_HI.
    - din_s=1 → S_HIGH, cnt<=0, no pulse.
    - din_s=0 and cnt==STABLE-1 → S_LOW, level<=0, fall<=1.
- Outputs:
  - All outputs are registered.
  - rise and fall are high for exactly one cycle and are never high together.
- Latency: from the first clk edge that samples din high (with din held) to level=1 is SYNC_STAGES+STABLE edges. With the defaults that is 6 edges, and fall timing is identical.
- Glitch rejection: any din_s excursion shorter than STABLE cycles produces no change on level, rise, fall, tog or press_cnt.
- Wrap-around: press_cnt at 2^PRESS_W-1 plus one accepted rise → 0, with no flag.
- Reset mid-qualification:
  - All state clears immediately and no pulse is emitted.
  - If din is still high after rst deasserts, the input requalifies from S_LOW and a full latency later emits exactly one rise.
- cnt never exceeds STABLE-1. Unused state encodings recover to S_LOW on the next edge.

Test Plan:
- Reset then din=1 held (defaults) → level=1 and rise=1 for one cycle at edge 6 after din first sampled; tog=1; press_cnt=1.
- From a stable high, din=0 for 3 cycles then back to 1 → level stays 1; rise/fall/press_cnt unchanged.
- From a stable high, din=0 held → fall=1 for one cycle and level=0 at edge 6; tog unchanged.
- 17 clean press/release cycles, each phase held 10 cycles → press_cnt wraps 15→0→1 (final 1); tog=1; 17 rise and 17 fall pulses, never overlapping.
- Assert rst for 1 cycle while in S_QUAL_HI (cnt=2), din held 1 → outputs 0 immediately (mid-cycle); one rise 6 edges after rst deasserts; press_cnt=1.
- din toggling every cycle for 50 cycles → no rise/fall pulses; level stays at its prior value.
